// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: prepends destination MAC, source MAC and EtherType
// to a payload byte stream and truncates payloads longer than MAX_PAYLOAD.
module eth_tx_framer #(
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 rst_n,
  input  logic                 i_eth_tx_valid,
  input  logic [7:0]           i_eth_tx_data,
  input  logic                 i_eth_tx_last,
  output logic                 o_eth_tx_ready,
  input  logic [47:0]          i_dst_mac,
  input  logic [15:0]          i_ethertype,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CNT_WIDTH-1:0] o_frames_sent,
  output logic [CNT_WIDTH-1:0] o_frames_trunc,
  output logic                 o_busy
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [16:0]          MAX_LEN = 17'(MAX_PAYLOAD);

  state_t      state;
  logic [47:0] dst_q;
  logic [15:0] type_q;
  logic [3:0]  hdr_idx;
  logic [15:0] pay_cnt;
  logic        ld;
  logic        in_hs;
  logic        at_max;

  assign ld     = !m_axis_tvalid || m_axis_tready;
  assign in_hs  = i_eth_tx_valid && o_eth_tx_ready;
  assign at_max = ({1'b0, pay_cnt} + 17'd1) == MAX_LEN;
  assign o_busy = (state != IDLE);

  always_comb begin
    case (state)
      PAYLOAD: o_eth_tx_ready = ld;
      DROP:    o_eth_tx_ready = 1'b1;
      default: o_eth_tx_ready = 1'b0;
    endcase
  end

  // Header is dst MAC, source MAC, EtherType, each most significant byte first.
  function automatic logic [7:0] hdr_byte(input logic [3:0]  idx,
                                          input logic [47:0] dst,
                                          input logic [15:0] et);
    logic [111:0] hdr;
    hdr = {dst, SRC_MAC, et} << {idx, 3'b000};
    return hdr[111:104];
  endfunction

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dst_q          <= '0;
      type_q         <= '0;
      hdr_idx        <= '0;
      pay_cnt        <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= 1'b0;
      o_frames_sent  <= '0;
      o_frames_trunc <= '0;
    end else begin
      // A consumed output byte is dropped unless a new one is loaded below.
      if (ld) m_axis_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_eth_tx_valid) begin
            dst_q   <= i_dst_mac;
            type_q  <= i_ethertype;
            hdr_idx <= '0;
            pay_cnt <= '0;
            state   <= HEADER;
          end
        end
        HEADER: begin
          if (ld) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hdr_byte(hdr_idx, dst_q, type_q);
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            hdr_idx       <= hdr_idx + 4'd1;
            if (hdr_idx == 4'd13) state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (in_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= i_eth_tx_data;
            pay_cnt       <= pay_cnt + 16'd1;
            if (i_eth_tx_last) begin
              m_axis_tlast  <= 1'b1;
              m_axis_tuser  <= 1'b0;
              o_frames_sent <= o_frames_sent + CNT_ONE;
              state         <= IDLE;
            end else if (at_max) begin
              m_axis_tlast   <= 1'b1;
              m_axis_tuser   <= 1'b1;
              o_frames_trunc <= o_frames_trunc + CNT_ONE;
              state          <= DROP;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= 1'b0;
            end
          end
        end
        DROP: begin
          if (in_hs && i_eth_tx_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: random payloads and ready patterns against a frame-level
// model that builds the expected byte stream from header fields and payload length.
module tb_eth_tx_framer;
  localparam logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01;
  localparam int          MAX_PAYLOAD = 1500;
  localparam int          CNT_WIDTH   = 16;

  logic                 i_clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_eth_tx_valid = 1'b0;
  logic [7:0]           i_eth_tx_data = '0;
  logic                 i_eth_tx_last = 1'b0;
  logic                 o_eth_tx_ready;
  logic [47:0]          i_dst_mac = '0;
  logic [15:0]          i_ethertype = '0;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready = 1'b0;
  logic                 m_axis_tlast;
  logic                 m_axis_tuser;
  logic [CNT_WIDTH-1:0] o_frames_sent;
  logic [CNT_WIDTH-1:0] o_frames_trunc;
  logic                 o_busy;

  eth_tx_framer #(.SRC_MAC(SRC_MAC), .MAX_PAYLOAD(MAX_PAYLOAD), .CNT_WIDTH(CNT_WIDTH)) dut (
    .i_clk(i_clk), .rst_n(rst_n),
    .i_eth_tx_valid(i_eth_tx_valid), .i_eth_tx_data(i_eth_tx_data),
    .i_eth_tx_last(i_eth_tx_last), .o_eth_tx_ready(o_eth_tx_ready),
    .i_dst_mac(i_dst_mac), .i_ethertype(i_ethertype),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .o_frames_sent(o_frames_sent),
    .o_frames_trunc(o_frames_trunc), .o_busy(o_busy)
  );

  always #4 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle each cycle, 2: random
  bit abort = 1'b0;
  logic [15:0] exp_sent = '0;
  logic [15:0] exp_trunc = '0;

  logic [7:0] pay_q[$];
  logic [9:0] exp_q[$];  // {tuser, tlast, tdata}
  logic [9:0] cap_q[$];
  int         cap_cyc[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output capture and hold-while-stalled protocol check.
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word = '0;
  always @(negedge i_clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_word) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b word=%03h, expected valid=1 word=%03h",
                   m_axis_tvalid, {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_word);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        cap_cyc.push_back(cyc);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  // Reference model: expected output bytes and counters for one input frame.
  task automatic model_frame(input logic [47:0] dst, input logic [15:0] et);
    logic [111:0] hdr;
    int n, m;
    hdr = {dst, SRC_MAC, et};
    n = pay_q.size();
    m = (n > MAX_PAYLOAD) ? MAX_PAYLOAD : n;
    for (int k = 0; k < 14; k++) exp_q.push_back({2'b00, hdr[111 - 8*k -: 8]});
    for (int j = 0; j < m; j++)
      exp_q.push_back({(j == m - 1) && (n > MAX_PAYLOAD), j == m - 1, pay_q[j]});
    if (n > MAX_PAYLOAD) exp_trunc = exp_trunc + 16'd1;
    else                 exp_sent  = exp_sent + 16'd1;
  endtask

  task automatic fill_random(input int n);
    pay_q.delete();
    for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  function automatic int first_mismatch();
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) if (cap_q[k] !== exp_q[k]) return k;
    return -1;
  endfunction

  task automatic clear_queues();
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  // Drives pay_q as one frame; header inputs are scrambled after the first accepted byte.
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et);
    int  i, n, budget;
    logic hs;
    i = 0;
    n = pay_q.size();
    budget = 4 * n + 200;
    i_dst_mac      = dst;
    i_ethertype    = et;
    i_eth_tx_valid = 1'b1;
    i_eth_tx_data  = pay_q[0];
    i_eth_tx_last  = (n == 1);
    while (i < n && !abort) begin
      @(negedge i_clk);
      hs = o_eth_tx_ready && i_eth_tx_valid;
      @(posedge i_clk);
      #1;
      if (hs) begin
        i++;
        i_dst_mac   = 48'({$urandom(), $urandom()});
        i_ethertype = 16'($urandom());
        if (i < n) begin
          i_eth_tx_data = pay_q[i];
          i_eth_tx_last = (i == n - 1);
        end
      end
      budget--;
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: accepted %0d of %0d bytes", i, n);
        break;
      end
    end
    i_eth_tx_valid = 1'b0;
    i_eth_tx_last  = 1'b0;
  endtask

  task automatic wait_cap(input int n);
    int budget;
    budget = 4 * n + 200;
    while (cap_q.size() < n && budget > 0) begin
      @(negedge i_clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: got %0d bytes, expected %0d", cap_q.size(), n);
    end
    repeat (4) @(posedge i_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} !== 11'd0) begin
      errors++;
      $display("FAIL reset_axis: got %b, expected all zero",
               {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser});
    end
    checks++;
    if ({o_eth_tx_ready, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/busy=%b, expected 00", {o_eth_tx_ready, o_busy});
    end
    checks++;
    if (o_frames_sent !== 16'd0 || o_frames_trunc !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got sent=%0d trunc=%0d, expected 0 0", o_frames_sent, o_frames_trunc);
    end
    @(negedge i_clk);
    rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] ref_bytes [15];
    int start, mm;
    ref_bytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h02, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h01, 8'h88, 8'hB5, 8'hA5};
    clear_queues();
    rdy_mode = 0;
    for (int k = 0; k < 15; k++) exp_q.push_back({1'b0, k == 14, ref_bytes[k]});
    exp_sent = exp_sent + 16'd1;
    pay_q.delete();
    pay_q.push_back(8'hA5);
    @(posedge i_clk);
    #1;
    start = cyc;
    send_frame(48'h0011_2233_4455, 16'h88B5);
    wait_cap(15);
    checks++;
    if (cap_q.size() !== 15) begin
      errors++;
      $display("FAIL single_len: got %0d bytes, expected 15", cap_q.size());
    end
    mm = first_mismatch();
    checks++;
    if (mm !== -1) begin
      errors++;
      $display("FAIL single_byte[%0d]: got %03h, expected %03h", mm, cap_q[mm], exp_q[mm]);
    end
    if (cap_cyc.size() >= 15) begin
      checks++;
      if (cap_cyc[0] - start !== 2 || cap_cyc[14] - start !== 16) begin
        errors++;
        $display("FAIL single_latency: got first=%0d last=%0d, expected 2 16",
                 cap_cyc[0] - start, cap_cyc[14] - start);
      end
    end
    checks++;
    if (o_frames_sent !== exp_sent) begin
      errors++;
      $display("FAIL single_sent: got %0d, expected %0d", o_frames_sent, exp_sent);
    end
  endtask

  task automatic test_stall_toggle();
    logic [47:0] dst;
    logic [15:0] et;
    int mm;
    clear_queues();
    rdy_mode = 1;
    dst = 48'({$urandom(), $urandom()});
    et  = 16'($urandom());
    pay_q.delete();
    for (int k = 0; k < 46; k++) pay_q.push_back(8'(k));
    model_frame(dst, et);
    send_frame(dst, et);
    wait_cap(60);
    checks++;
    if (cap_q.size() !== 60) begin
      errors++;
      $display("FAIL stall_len: got %0d bytes, expected 60", cap_q.size());
    end
    mm = first_mismatch();
    checks++;
    if (mm !== -1) begin
      errors++;
      $display("FAIL stall_byte[%0d]: got %03h, expected %03h", mm, cap_q[mm], exp_q[mm]);
    end
    rdy_mode = 0;
  endtask

  task automatic test_oversize(input int n, input string name);
    logic [47:0] dst;
    logic [15:0] et;
    int mm;
    clear_queues();
    rdy_mode = 0;
    dst = 48'({$urandom(), $urandom()});
    et  = 16'($urandom());
    fill_random(n);
    model_frame(dst, et);
    send_frame(dst, et);
    wait_cap(exp_q.size());
    checks++;
    if (cap_q.size() !== 1514) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes, expected 1514", name, cap_q.size());
    end
    mm = first_mismatch();
    checks++;
    if (mm !== -1) begin
      errors++;
      $display("FAIL %s_byte[%0d]: got %03h, expected %03h", name, mm, cap_q[mm], exp_q[mm]);
    end
    checks++;
    if (o_frames_sent !== exp_sent || o_frames_trunc !== exp_trunc) begin
      errors++;
      $display("FAIL %s_counters: got sent=%0d trunc=%0d, expected %0d %0d",
               name, o_frames_sent, o_frames_trunc, exp_sent, exp_trunc);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b, expected 0", name, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] dst [3];
    logic [15:0] et;
    logic [7:0]  pays [3][10];
    int mm;
    clear_queues();
    rdy_mode = 0;
    et = 16'h0800;
    for (int f = 0; f < 3; f++) begin
      dst[f] = 48'({$urandom(), $urandom()}) ^ 48'(f);
      fill_random(10);
      for (int k = 0; k < 10; k++) pays[f][k] = pay_q[k];
      model_frame(dst[f], et);
    end
    for (int f = 0; f < 3; f++) begin
      pay_q.delete();
      for (int k = 0; k < 10; k++) pay_q.push_back(pays[f][k]);
      send_frame(dst[f], et);
    end
    wait_cap(72);
    checks++;
    if (cap_q.size() !== 72) begin
      errors++;
      $display("FAIL b2b_len: got %0d bytes, expected 72", cap_q.size());
    end
    mm = first_mismatch();
    checks++;
    if (mm !== -1) begin
      errors++;
      $display("FAIL b2b_byte[%0d]: got %03h, expected %03h", mm, cap_q[mm], exp_q[mm]);
    end
    if (cap_cyc.size() >= 72) begin
      checks++;
      if (cap_cyc[24] - cap_cyc[23] !== 2 || cap_cyc[48] - cap_cyc[47] !== 2) begin
        errors++;
        $display("FAIL b2b_gap: got %0d %0d cycles, expected 2 2",
                 cap_cyc[24] - cap_cyc[23], cap_cyc[48] - cap_cyc[47]);
      end
    end
    checks++;
    if (o_frames_sent !== exp_sent) begin
      errors++;
      $display("FAIL b2b_sent: got %0d, expected %0d", o_frames_sent, exp_sent);
    end
  endtask

  task automatic test_random();
    logic [47:0] dst;
    logic [15:0] et;
    int mm;
    clear_queues();
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      dst = 48'({$urandom(), $urandom()});
      et  = 16'($urandom());
      fill_random($urandom_range(1, 80));
      model_frame(dst, et);
      send_frame(dst, et);
    end
    wait_cap(exp_q.size());
    checks++;
    if (cap_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_len: got %0d bytes, expected %0d", cap_q.size(), exp_q.size());
    end
    mm = first_mismatch();
    checks++;
    if (mm !== -1) begin
      errors++;
      $display("FAIL random_byte[%0d]: got %03h, expected %03h", mm, cap_q[mm], exp_q[mm]);
    end
    checks++;
    if (o_frames_sent !== exp_sent) begin
      errors++;
      $display("FAIL random_sent: got %0d, expected %0d", o_frames_sent, exp_sent);
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] dst;
    logic [15:0] et;
    int mm, budget;
    clear_queues();
    rdy_mode = 0;
    fill_random(20);
    fork
      send_frame(48'h0A0B_0C0D_0E0F, 16'h1234);
      begin
        budget = 300;
        while (cap_q.size() < 19 && budget > 0) begin
          @(negedge i_clk);
          budget--;
        end
        #1;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, o_eth_tx_ready, o_busy} !== 13'd0) begin
          errors++;
          $display("FAIL midreset_outputs: got %b, expected all zero",
                   {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, o_eth_tx_ready, o_busy});
        end
        checks++;
        if (o_frames_sent !== 16'd0 || o_frames_trunc !== 16'd0) begin
          errors++;
          $display("FAIL midreset_counters: got sent=%0d trunc=%0d, expected 0 0",
                   o_frames_sent, o_frames_trunc);
        end
      end
    join
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    rst_n = 1'b1;
    abort = 1'b0;
    exp_sent  = '0;
    exp_trunc = '0;
    repeat (2) @(posedge i_clk);
    #1;
    clear_queues();
    dst = 48'({$urandom(), $urandom()});
    et  = 16'($urandom());
    fill_random(4);
    model_frame(dst, et);
    send_frame(dst, et);
    wait_cap(18);
    checks++;
    if (cap_q.size() !== 18) begin
      errors++;
      $display("FAIL midreset_len: got %0d bytes, expected 18", cap_q.size());
    end
    mm = first_mismatch();
    checks++;
    if (mm !== -1) begin
      errors++;
      $display("FAIL midreset_byte[%0d]: got %03h, expected %03h", mm, cap_q[mm], exp_q[mm]);
    end
    checks++;
    if (o_frames_sent !== 16'd1) begin
      errors++;
      $display("FAIL midreset_sent: got %0d, expected 1", o_frames_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stall_toggle();
    test_oversize(1502, "oversize");
    test_oversize(1500, "exact_max");
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
